pll_50_to_25: RTL and testbench
===============================

PLL_50_TO_25 -- requirements
Module: pll_50_to_25

Interface
REQ-001 Parameter: DIV, default 2, inclk0-to-c0 division ratio; even integer, 2..256.
REQ-002 Parameter: LOCK_CYCLES, default 1024, number of c0 rising edges before lock; integer, 1..65535.
REQ-003 Port: inclk0  input  1  reference clock, 50 MHz nominal; sole clock of the block.
REQ-004 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: c0  output  1  derived clock, inclk0/DIV (25 MHz at default), 50% duty.
REQ-006 Port: locked  output  1  high once c0 is stable; consumers AND it into their own reset.
REQ-007 One clock; reset is asynchronous and active-low. Ports are named inclk0 and rst_n.

Function
REQ-008 All sequential logic SHALL be clocked on the rising edge of inclk0 only.
REQ-009 Purely synthesizable behavioural logic; no vendor PLL primitives or delays.
REQ-010 c0 SHALL be driven directly from a flip-flop output, with no combinational logic after it.
REQ-011 Divider: phase counter, width clog2(DIV), counts 0..DIV-1 and wraps to 0.
REQ-012 For the k-th inclk0 rising edge after reset release (k = 1, 2, ...), c0 SHALL be 1 iff ((k-1) mod DIV) < DIV/2.
REQ-013 Consequence of REQ-012: c0 period = DIV inclk0 cycles; high DIV/2 cycles, low DIV/2 cycles; first rise on edge 1.
REQ-014 Lock counter: width clog2(LOCK_CYCLES+1); increments on each inclk0 edge where c0 goes 0->1.
REQ-015 Lock counter SHALL saturate at LOCK_CYCLES and never wrap.
REQ-016 locked SHALL go high on the same inclk0 edge that produces the LOCK_CYCLES-th c0 rise.
REQ-017 locked is sticky: once high, it stays high until rst_n is asserted.
REQ-018 c0 SHALL run continuously from the first post-reset edge, whether or not locked is high.
REQ-019 No other outputs or status bits.

Reset
REQ-020 While rst_n = 0: c0 = 0, locked = 0, phase counter = 0, lock counter = 0, applied asynchronously.
REQ-021 Reset asserted mid-operation: c0 and locked SHALL drop to 0 immediately, without waiting for an inclk0 edge.
REQ-022 Reset asserted mid-operation: lock progress is discarded; after release, the sequence restarts exactly per REQ-012 and REQ-016.
REQ-023 Reset release is synchronised by the first inclk0 rising edge; that edge counts as k = 1.

Verification
REQ-024 DIV=2, LOCK_CYCLES=8, release rst_n, 20 inclk0 edges.
  - c0 SHALL be 1,0,1,0,... after edges 1,2,3,4,...
  - locked SHALL be 0 through edge 14 and 1 from edge 15 onward.
REQ-025 DIV=4, LOCK_CYCLES=3.
  - c0 after edges 1..8 SHALL be 1,1,0,0,1,1,0,0.
  - locked SHALL rise at edge 9.
REQ-026 Lock held: DIV=2, LOCK_CYCLES=8, run 1000 edges after lock.
  - locked SHALL stay 1 continuously.
  - c0 SHALL keep exact 50% duty with period 2 edges.
REQ-027 Mid-run reset: DIV=2, LOCK_CYCLES=8.
  - Pulse rst_n low between edges 20 and 21 with no edge during the pulse.
  - c0 and locked SHALL read 0 during the pulse.
  - After release, the REQ-024 sequence SHALL repeat exactly, including locked at post-release edge 15.
REQ-028 Defaults (DIV=2, LOCK_CYCLES=1024), 50 MHz inclk0.
  - Measured c0 frequency SHALL be 25 MHz.
  - locked SHALL rise at edge 2047.
REQ-029 Reset held low for 100 inclk0 edges: c0 and locked SHALL remain 0 throughout.

Source files
------------

// File: rtl/pll_50_to_25.sv
// -----------------------------------------------------------------------------
// pll_50_to_25
//
// Behavioural clock divider with a lock indicator, standing in for a vendor
// PLL that turns a 50 MHz reference into 25 MHz. Everything runs on the rising
// edge of inclk0. No vendor primitives are used.
//
// Parameters
//   DIV          even integer, 2..256. c0 period in inclk0 cycles.
//   LOCK_CYCLES  1..65535. Number of c0 rising edges seen before locked rises.
//
// Ports
//   inclk0  in   reference clock; the only clock of the block
//   rst_n   in   asynchronous active-low reset
//   c0      out  inclk0/DIV, 50% duty; driven straight from a flip-flop
//   locked  out  sticky "c0 is stable" flag; clears only on reset
//
// Timing: the first inclk0 rising edge after reset release is edge k = 1.
// After edge k, c0 = 1 iff ((k-1) mod DIV) < DIV/2. So c0 first rises on
// edge 1. locked rises on the same edge that produces the LOCK_CYCLES-th
// rising edge of c0.
// -----------------------------------------------------------------------------
module pll_50_to_25 #(
   parameter int DIV         = 2,
   parameter int LOCK_CYCLES = 1024
) (
   input  logic inclk0,
   input  logic rst_n,
   output logic c0,
   output logic locked
);

   localparam int PW = $clog2(DIV);
   localparam int CW = $clog2(LOCK_CYCLES + 1);

   localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
   localparam logic [PW-1:0] PH_HALF  = PW'(DIV / 2);
   localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_CYCLES);

   logic [PW-1:0] phase_q, phase_d;
   logic          c0_q, c0_d;
   logic [CW-1:0] lock_cnt_q, lock_cnt_d;
   logic          locked_q, locked_d;
   logic          c0_rise;

   always_comb begin
      phase_d    = phase_q;
      c0_d       = 1'b0;
      c0_rise    = 1'b0;
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_q;

      // phase_q holds (k-1) mod DIV ahead of edge k. The output level for
      // edge k is therefore decoded from the current phase and registered.
      if (phase_q == PH_LAST) begin
         phase_d = '0;
      end else begin
         phase_d = phase_q + PW'(1);
      end
      c0_d = (phase_q < PH_HALF);

      // Count the edges where the registered c0 goes 0->1. The count
      // saturates so that a long run cannot wrap it.
      c0_rise = c0_d & ~c0_q;
      if (c0_rise && (lock_cnt_q != LOCK_MAX)) begin
         lock_cnt_d = lock_cnt_q + CW'(1);
      end

      // Sticky. Looking at lock_cnt_d makes locked rise on the same edge
      // as the final counted c0 rise, not one edge later.
      if (lock_cnt_d == LOCK_MAX) begin
         locked_d = 1'b1;
      end
   end

   always_ff @(posedge inclk0 or negedge rst_n) begin
      if (!rst_n) begin
         phase_q    <= '0;
         c0_q       <= 1'b0;
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         c0_q       <= c0_d;
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
      end
   end

   assign c0     = c0_q;
   assign locked = locked_q;

endmodule

// File: tb/tb_pll_50_to_25.sv
// -----------------------------------------------------------------------------
// tb_pll_50_to_25
//
// Four divider configurations share one inclk0 and one rst_n:
//   a: DIV=2, LOCK_CYCLES=8
//   b: DIV=4, LOCK_CYCLES=3
//   c: defaults (DIV=2, LOCK_CYCLES=1024)
//   d: DIV=6, LOCK_CYCLES=1
//
// The stimulus process counts edges since reset release. For each edge it
// pushes the expected {c0,locked} of every instance, taken from the reference
// model, onto exp_q. The monitor pops one entry per falling edge and compares
// it with the DUT outputs. The checks of the asynchronous reset pulse happen
// between clock edges, so the stimulus process makes them itself.
// -----------------------------------------------------------------------------
module tb_pll_50_to_25;

   localparam int W = 8;

   logic inclk0;
   logic rst_n;
   logic c0_a, locked_a, c0_b, locked_b, c0_c, locked_c, c0_d, locked_d;

   logic [W-1:0] exp_q[$];
   int           n_checks;
   int           n_fail;
   int           k;            // edges since reset release (0 = in reset)
   bit           stim_done;

   // ---------------- clock / reset ----------------
   initial begin
      inclk0 = 1'b0;
      forever #10 inclk0 = ~inclk0;   // 50 MHz
   end

   // ---------------- DUTs ----------------
   pll_50_to_25 #(.DIV(2), .LOCK_CYCLES(8)) u_a (
      .inclk0(inclk0), .rst_n(rst_n), .c0(c0_a), .locked(locked_a));
   pll_50_to_25 #(.DIV(4), .LOCK_CYCLES(3)) u_b (
      .inclk0(inclk0), .rst_n(rst_n), .c0(c0_b), .locked(locked_b));
   pll_50_to_25 u_c (
      .inclk0(inclk0), .rst_n(rst_n), .c0(c0_c), .locked(locked_c));
   pll_50_to_25 #(.DIV(6), .LOCK_CYCLES(1)) u_d (
      .inclk0(inclk0), .rst_n(rst_n), .c0(c0_d), .locked(locked_d));

   function automatic logic [W-1:0] dut_out();
      return {c0_a, locked_a, c0_b, locked_b, c0_c, locked_c, c0_d, locked_d};
   endfunction

   // ---------------- reference model ----------------
   // c0 after edge k: high during the first half of each DIV-edge period.
   // locked after edge k: c0 rises on edges 1, 1+DIV, 1+2*DIV, ...
   // so the LC-th rise is on edge (LC-1)*DIV + 1.
   function automatic logic [1:0] ref_pair(int kk, int div, int lc);
      logic c, l;
      c = (kk > 0) && (((kk - 1) % div) < (div / 2));
      l = (kk > 0) && (kk >= (lc - 1) * div + 1);
      return {c, l};
   endfunction

   function automatic logic [W-1:0] ref_model(int kk);
      return {ref_pair(kk, 2, 8), ref_pair(kk, 4, 3),
              ref_pair(kk, 2, 1024), ref_pair(kk, 6, 1)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge inclk0);
      if (rst_n) k = k + 1;
      else       k = 0;
      exp_q.push_back(ref_model(k));
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Make the next rst_n change well away from the rising edge.
   task automatic mid_cycle();
      @(negedge inclk0);
      #5;
   endtask

   task automatic release_reset();
      mid_cycle();
      rst_n = 1'b1;
   endtask

   task automatic hold_reset(int n);
      mid_cycle();
      rst_n = 1'b0;
      k     = 0;
      run(n);
      release_reset();
   endtask

   // Short low pulse with no rising edge inside it. Both outputs must drop
   // without waiting for a clock edge.
   task automatic pulse_reset();
      logic [W-1:0] got;
      mid_cycle();
      rst_n = 1'b0;
      k     = 0;
      #1;
      got = dut_out();
      n_checks++;
      if (got !== '0) begin
         n_fail++;
         $display("FAIL async_reset t=%0t got %b exp %b", $time, got, {W{1'b0}});
      end
      #2;
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks  = 0;
      n_fail    = 0;
      k         = 0;
      stim_done = 1'b0;
      rst_n     = 1'b0;

      #1;
      n_checks++;
      if (dut_out() !== '0) begin
         n_fail++;
         $display("FAIL reset_state got %b exp %b", dut_out(), {W{1'b0}});
      end

      run(5);
      release_reset();
      run(2100);           // default lock at 2047, then more than 1000 locked edges for a
      pulse_reset();       // mid-run reset while every instance is locked
      run(20);
      pulse_reset();       // reset between edges 20 and 21
      run(30);
      hold_reset(100);     // reset held low for 100 edges
      run(40);

      for (int r = 0; r < 10; r++) begin
         run($urandom_range(1, 300));
         if ($urandom_range(0, 1) == 0) pulse_reset();
         else                            hold_reset($urandom_range(1, 5));
      end
      run(50);
      stim_done = 1'b1;
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [W-1:0] exp_v;
      logic [W-1:0] got;
      int           idle;
      idle = 0;
      forever begin
         @(negedge inclk0);
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got   = dut_out();
            n_checks++;
            if (got !== exp_v) begin
               n_fail++;
               $display("FAIL edge_check t=%0t got %b exp %b", $time, got, exp_v);
            end
         end else if (stim_done) begin
            idle++;
            if (idle > 4) break;
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain left=%0d exp 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global bound so the run always ends.
   initial begin
      #2000000;
      n_fail++;
      $display("FAIL timeout t=%0t", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
